// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_pkg
// Description : Shared op codes, FSM state type and decode helpers for the
//               M-extension multiply/divide unit.
// Revision    : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

  // mulDiv_op encodings as produced by the instruction decoder
  localparam logic [3:0] OP_MUL    = 4'b0011;
  localparam logic [3:0] OP_MULH   = 4'b0101;
  localparam logic [3:0] OP_MULHU  = 4'b0111;
  localparam logic [3:0] OP_MULHSU = 4'b0110;
  localparam logic [3:0] OP_DIV    = 4'b1001;
  localparam logic [3:0] OP_DIVU   = 4'b1011;
  localparam logic [3:0] OP_REM    = 4'b1101;
  localparam logic [3:0] OP_REMU   = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  function automatic logic is_mul_op(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHU) || (op == OP_MULHSU);
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
  endfunction

  // Divides resolved without iterating: divide-by-zero, and the signed
  // most-negative / -1 overflow. Operand properties are passed as flags so
  // the helper stays independent of the operand width.
  function automatic logic is_special_div(input logic [3:0] op,
                                          input logic       b_zero,
                                          input logic       a_min,
                                          input logic       b_ones);
    return is_div_op(op) && (b_zero || (!op[1] && a_min && b_ones));
  endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_div_core.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_div_core
// Description : Unsigned radix-2 restoring divider, one quotient bit per step.
//               Exposes the result of the step in progress so the caller can
//               capture the final quotient/remainder on the last step.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_div_core #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic            start,
  input  logic            step,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quo_next,
  output logic [XLEN-1:0] rem_next,
  output logic            last
);

  localparam int CNT_W = $clog2(XLEN);

  logic [XLEN-1:0]  quo_q, quo_d;
  logic [XLEN-1:0]  rem_q, rem_d;
  logic [XLEN-1:0]  dvs_q, dvs_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [XLEN:0]    trial;
  logic [XLEN:0]    diff;
  logic [XLEN-1:0]  rem_step;
  logic             q_bit;

  // One restoring step: shift the next dividend bit into the partial
  // remainder and keep the subtraction only if it did not go negative.
  always_comb begin
    trial    = {rem_q, quo_q[XLEN-1]};
    diff     = trial - {1'b0, dvs_q};
    q_bit    = ~diff[XLEN];
    rem_step = diff[XLEN] ? trial[XLEN-1:0] : diff[XLEN-1:0];
  end

  assign quo_next = {quo_q[XLEN-2:0], q_bit};
  assign rem_next = rem_step;
  assign last     = (cnt_q == '0);

  // Load operands on start, otherwise advance one bit per step.
  always_comb begin
    quo_d = quo_q;
    rem_d = rem_q;
    dvs_d = dvs_q;
    cnt_d = cnt_q;
    if (start) begin
      quo_d = dividend;
      rem_d = '0;
      dvs_d = divisor;
      cnt_d = CNT_W'(XLEN - 1);
    end else if (step) begin
      quo_d = quo_next;
      rem_d = rem_next;
      if (cnt_q != '0) begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  // Divider state registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
    end else begin
      quo_q <= quo_d;
      rem_q <= rem_d;
      dvs_q <= dvs_d;
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Execute-stage multiply/divide unit. Registered multiply,
//               iterative restoring divide with sign fix-up, fast path for
//               divide special cases, valid/ready handshake and flush.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_op,
  input  logic [XLEN-1:0]  req_a,
  input  logic [XLEN-1:0]  req_b,
  input  logic [TAG_W-1:0] req_tag,
  input  logic             flush,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [XLEN-1:0]  resp_data,
  output logic [TAG_W-1:0] resp_tag,
  output logic             busy
);

  import muldiv_pkg::*;

  state_e           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [XLEN-1:0]  a_q, a_d;
  logic [XLEN-1:0]  b_q, b_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic [XLEN-1:0]  resp_data_q, resp_data_d;
  logic [TAG_W-1:0] resp_tag_q, resp_tag_d;
  logic             resp_valid_q, resp_valid_d;
  logic             req_ready_q, req_ready_d;
  logic             busy_q, busy_d;

  logic              accept;
  logic              a_neg, b_neg;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic              b_zero, special;
  logic [XLEN-1:0]   special_res;
  logic              mul_a_sgn, mul_b_sgn;
  logic [2*XLEN-1:0] mul_a_ext, mul_b_ext, product;
  logic [XLEN-1:0]   mul_res;
  logic              div_start, div_step, div_last;
  logic [XLEN-1:0]   quo_next, rem_next, div_res;

  assign accept = req_valid & req_ready_q & ~flush;

  // Signed divides operate on magnitudes; op[1] low means signed.
  assign a_neg = ~req_op[1] & req_a[XLEN-1];
  assign b_neg = ~req_op[1] & req_b[XLEN-1];
  assign mag_a = a_neg ? -req_a : req_a;
  assign mag_b = b_neg ? -req_b : req_b;

  assign b_zero  = (req_b == '0);
  assign special = is_special_div(req_op, b_zero,
                                  req_a == {1'b1, {(XLEN-1){1'b0}}}, &req_b);
  // Divide by zero: quotient all ones, remainder a. Overflow: quotient a, remainder 0.
  assign special_res = b_zero ? (req_op[2] ? req_a : '1) : (req_op[2] ? '0 : req_a);

  // Sign-extend to the full product width so one unsigned multiply serves
  // all signedness combinations.
  assign mul_a_sgn = (op_q[1:0] != 2'b11);
  assign mul_b_sgn = (op_q[1:0] == 2'b01);
  assign mul_a_ext = {{XLEN{mul_a_sgn & a_q[XLEN-1]}}, a_q};
  assign mul_b_ext = {{XLEN{mul_b_sgn & b_q[XLEN-1]}}, b_q};
  assign product   = mul_a_ext * mul_b_ext;
  assign mul_res   = (op_q == OP_MUL) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];

  // Sign fix-up of the final divider step, selected by op[2].
  assign div_res = op_q[2] ? (neg_rem_q ? -rem_next : rem_next)
                           : (neg_quo_q ? -quo_next : quo_next);

  muldiv_div_core #(
    .XLEN (XLEN)
  ) u_div_core (
    .clk      (clk),
    .nrst     (nrst),
    .start    (div_start),
    .step     (div_step),
    .dividend (mag_a),
    .divisor  (mag_b),
    .quo_next (quo_next),
    .rem_next (rem_next),
    .last     (div_last)
  );

  // Next-state and next-output logic; flush overrides completion and handshake.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    resp_data_d = resp_data_q;
    resp_tag_d  = resp_tag_q;
    div_start   = 1'b0;
    div_step    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept && is_mul_op(req_op)) begin
          state_d    = S_MUL;
          op_d       = req_op;
          a_d        = req_a;
          b_d        = req_b;
          resp_tag_d = req_tag;
        end else if (accept && is_div_op(req_op)) begin
          op_d       = req_op;
          resp_tag_d = req_tag;
          if (special) begin
            state_d     = S_DONE;
            resp_data_d = special_res;
          end else begin
            state_d   = S_DIV;
            div_start = 1'b1;
            neg_quo_d = a_neg ^ b_neg;
            neg_rem_d = a_neg;
          end
        end
      end
      S_MUL: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          state_d     = S_DONE;
          resp_data_d = mul_res;
        end
      end
      S_DIV: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          div_step = 1'b1;
          if (div_last) begin
            state_d     = S_DONE;
            resp_data_d = div_res;
          end
        end
      end
      S_DONE: begin
        if (flush || resp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    resp_valid_d = (state_d == S_DONE);
    req_ready_d  = (state_d == S_IDLE);
    busy_d       = (state_d != S_IDLE);
  end

  // FSM state, captured request and registered outputs.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q      <= S_IDLE;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      neg_quo_q    <= 1'b0;
      neg_rem_q    <= 1'b0;
      resp_data_q  <= '0;
      resp_tag_q   <= '0;
      resp_valid_q <= 1'b0;
      req_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      neg_quo_q    <= neg_quo_d;
      neg_rem_q    <= neg_rem_d;
      resp_data_q  <= resp_data_d;
      resp_tag_q   <= resp_tag_d;
      resp_valid_q <= resp_valid_d;
      req_ready_q  <= req_ready_d;
      busy_q       <= busy_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_tag   = resp_tag_q;
  assign busy       = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_unit
// Description : Self-checking bench for muldiv_unit against an arithmetic
//               reference model; directed cases plus randomized operations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

  localparam int XLEN  = 32;
  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             nrst = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [3:0]       req_op = 4'b0000;
  logic [XLEN-1:0]  req_a = '0;
  logic [XLEN-1:0]  req_b = '0;
  logic [TAG_W-1:0] req_tag = '0;
  logic             flush = 1'b0;
  logic             resp_valid;
  logic             resp_ready = 1'b0;
  logic [XLEN-1:0]  resp_data;
  logic [TAG_W-1:0] resp_tag;
  logic             busy;

  int n_checks = 0;
  int n_errors = 0;

  muldiv_unit #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk        (clk),
    .nrst       (nrst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_tag    (req_tag),
    .flush      (flush),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_tag   (resp_tag),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: RISC-V M-extension semantics in plain 64-bit arithmetic.
  function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                output bit has_resp, output logic [31:0] res, output int lat);
    longint sa, sb, p, q, r;
    has_resp = 1'b1;
    res      = '0;
    lat      = 0;
    case (op)
      4'b0011, 4'b0101, 4'b0111, 4'b0110: begin
        sa = (op == 4'b0111 || op == 4'b0011) ? longint'({32'd0, a}) : longint'($signed(a));
        sb = (op == 4'b0101) ? longint'($signed(b)) : longint'({32'd0, b});
        p  = sa * sb;
        res = (op == 4'b0011) ? p[31:0] : p[63:32];
        lat = 2;
      end
      4'b1001, 4'b1011, 4'b1101, 4'b1111: begin
        if (b == 32'd0) begin
          q = -1; r = longint'({32'd0, a}); lat = 1;
        end else if (op[1] == 1'b0 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          q = longint'({32'd0, a}); r = 0; lat = 1;
        end else begin
          if (op[1] == 1'b0) begin
            sa = longint'($signed(a)); sb = longint'($signed(b));
          end else begin
            sa = longint'({32'd0, a}); sb = longint'({32'd0, b});
          end
          q = sa / sb; r = sa % sb; lat = 33;
        end
        res = op[2] ? r[31:0] : q[31:0];
      end
      default: has_resp = 1'b0;
    endcase
  endfunction

  // Issue one request and check latency, data, tag and the handshake.
  // Entered and left one time unit after a rising edge.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag, input int hold, input string name);
    bit          has;
    logic [31:0] exp;
    int          elat, lat;
    model(op, a, b, has, exp, elat);
    lat = 0;
    while (!req_ready && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_tag = tag;
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (!has) begin
      lat = 0;
      for (int i = 0; i < 3; i++) begin
        if (resp_valid || busy) lat++;
        @(posedge clk); #1;
      end
      check_eq({name, " no_resp"}, lat, 0);
      check_eq({name, " ready"}, req_ready, 1'b1);
      return;
    end
    lat = 1;
    while (!resp_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    check_eq({name, " latency"}, lat, elat);
    check_eq({name, " data"}, resp_data, exp);
    check_eq({name, " tag"}, resp_tag, tag);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check_eq({name, " hold_valid"}, resp_valid, 1'b1);
      check_eq({name, " hold_data"}, resp_data, exp);
      check_eq({name, " hold_tag"}, resp_tag, tag);
      check_eq({name, " hold_ready"}, req_ready, 1'b0);
      check_eq({name, " hold_busy"}, busy, 1'b1);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check_eq({name, " post_valid"}, resp_valid, 1'b0);
    check_eq({name, " post_ready"}, req_ready, 1'b1);
  endtask

  logic [3:0]  op_tab [10] = '{4'b0011, 4'b0101, 4'b0111, 4'b0110,
                                4'b1001, 4'b1011, 4'b1101, 4'b1111,
                                4'b0000, 4'b1110};
  logic [31:0] val_tab [5] = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'd7};

  function automatic logic [31:0] rnd_operand();
    if ($urandom_range(0, 3) == 0) return val_tab[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  initial begin
    int seen;
    #12;
    check_eq("reset ready", req_ready, 1'b1);
    check_eq("reset valid", resp_valid, 1'b0);
    check_eq("reset busy", busy, 1'b0);
    check_eq("reset data", resp_data, 0);
    check_eq("reset tag", resp_tag, 0);
    nrst = 1'b1;
    @(posedge clk); #1;

    run_op(4'b0011, 32'd7, 32'hFFFF_FFFD, 5'd1, 0, "MUL");
    run_op(4'b0111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 0, "MULHU");
    run_op(4'b0101, 32'h8000_0000, 32'h8000_0000, 5'd3, 0, "MULH");
    run_op(4'b0110, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 0, "MULHSU");
    run_op(4'b1001, 32'hFFFF_FFF9, 32'd2, 5'd5, 0, "DIV");
    run_op(4'b1101, 32'hFFFF_FFF9, 32'd2, 5'd6, 0, "REM");
    run_op(4'b1011, 32'd100, 32'd7, 5'd7, 0, "DIVU");
    run_op(4'b1111, 32'd100, 32'd7, 5'd8, 0, "REMU");
    run_op(4'b1001, 32'd5, 32'd0, 5'd9, 0, "DIV0");
    run_op(4'b1101, 32'd5, 32'd0, 5'd10, 0, "REM0");
    run_op(4'b1001, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 0, "DIVOVF");
    run_op(4'b1101, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 0, "REMOVF");
    run_op(4'b0100, 32'd3, 32'd4, 5'd13, 0, "BADOP");

    // Flush on the 10th divide iteration kills the op.
    req_valid = 1'b1; req_op = 4'b1001; req_a = 32'd1000; req_b = 32'd3; req_tag = 5'd14;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check_eq("flush ready", req_ready, 1'b1);
    check_eq("flush busy", busy, 1'b0);
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      if (resp_valid) seen++;
      @(posedge clk); #1;
    end
    check_eq("flush no_resp", seen, 0);
    run_op(4'b0011, 32'd3, 32'd4, 5'd15, 0, "MUL_after_flush");

    // Flush in IDLE blocks acceptance.
    req_valid = 1'b1; flush = 1'b1; req_op = 4'b0011;
    @(posedge clk); #1;
    req_valid = 1'b0; flush = 1'b0;
    check_eq("idle_flush busy", busy, 1'b0);
    check_eq("idle_flush ready", req_ready, 1'b1);

    // Backpressure in DONE.
    run_op(4'b1011, 32'd12345, 32'd10, 5'd16, 5, "DIVU_hold");

    // Asynchronous reset mid-divide.
    req_valid = 1'b1; req_op = 4'b1001; req_a = 32'd999; req_b = 32'd5; req_tag = 5'd17;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    #1 nrst = 1'b0;
    #1;
    check_eq("rst busy", busy, 1'b0);
    check_eq("rst ready", req_ready, 1'b1);
    check_eq("rst valid", resp_valid, 1'b0);
    check_eq("rst data", resp_data, 0);
    check_eq("rst tag", resp_tag, 0);
    @(negedge clk);
    nrst = 1'b1;
    @(posedge clk); #1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (resp_valid) seen++;
      @(posedge clk); #1;
    end
    check_eq("rst no_resp", seen, 0);

    // Randomized operations.
    for (int n = 0; n < 50; n++) begin
      run_op(op_tab[$urandom_range(0, 9)], rnd_operand(), rnd_operand(),
             5'($urandom), $urandom_range(0, 2), $sformatf("rnd%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
